bus_tx_sequencer: RTL and testbench
===================================

# bus_tx_sequencer

Upstream stage for the 8-bit tri-state data driver. It buffers bytes from a producer in a small FIFO and arbitrates for the shared bus with a request/grant handshake. Once granted, it emits bursts of bytes on `drv_data` and holds `drv_en` high for exactly one clock per byte. `drv_data` connects to the driver's `data_in` and `drv_en` to its `enable`, so the bus is released (high impedance) whenever `drv_en` is low.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `BURST_MAX`, 4: maximum bytes driven per grant; must be at least 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte from the producer.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO not full; a push happens on a rising edge where `in_valid && in_ready`.
- `bus_req`  out  1  bus request to the arbiter.
- `bus_gnt`  in  1  bus grant from the arbiter.
- `drv_data`  out  8  byte to the tri-state driver.
- `drv_en`  out  1  enable to the tri-state driver.
- `busy`  out  1  state is not IDLE.
- `count`  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- **FIFO:** circular buffer with read and write pointers that wrap modulo DEPTH, plus an occupancy counter.
  - `in_ready = (count != DEPTH)`.
  - A push when full is not accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave `count` unchanged.
  - A pop happens on every rising edge while the state is DRIVE.
- **FSM:** states IDLE, REQ, DRIVE, TURN; the state register is the only state-dependent control.
  - IDLE: if `count != 0`, go to REQ; otherwise stay.
  - REQ: if `bus_gnt` is sampled 1, go to DRIVE and clear the burst counter; otherwise stay. There is no timeout.
  - DRIVE: pop the head and increment the burst counter. Go to TURN if any of the following holds, otherwise stay:
    - the FIFO becomes empty after this pop (`count` is 1 and no push this cycle), or
    - the burst counter equals BURST_MAX-1, or
    - `bus_gnt` is 0.
  - TURN: one bus-turnaround cycle, then IDLE unconditionally.
- **Outputs (decoded from the state register only, so they are glitch-free relative to the inputs):**
  - `bus_req = (state == REQ) || (state == DRIVE)`.
  - `drv_en = (state == DRIVE)`.
  - `drv_data` = FIFO head when in DRIVE, otherwise 8'h00.
- **Grant loss:** if `bus_gnt` falls during a DRIVE cycle, the byte driven in that cycle counts as transmitted and is popped. The block re-requests the bus after TURN and IDLE.
- **Reset (`rst_n` = 0):** takes effect immediately, independent of `clk`.
  - State goes to IDLE; pointers, `count` and the burst counter clear; FIFO contents are discarded.
  - Outputs while in reset: `drv_en`=0, `drv_data`=0, `bus_req`=0, `busy`=0, `count`=0, `in_ready`=1.
  - Reset asserted mid-burst drops `drv_en` asynchronously, so the driver goes high-Z at once.

## Timing
- **Startup latency:** a push into an empty FIFO at edge E0 while IDLE gives:
  - REQ after E1;
  - DRIVE after E2 if `bus_gnt` is already 1;
  - the first `drv_en` cycle spans E2 to E3.
- **Within a burst:** consecutive bytes appear on consecutive cycles with no gaps.
- **Between bursts:** the minimum gap with `drv_en` low is 3 cycles (TURN, IDLE, REQ).
- **TURN:** `drv_en` and `bus_req` are both 0 for at least one full cycle after every burst.
- **Concurrent pushes:** `in_ready` may stay 1 during DRIVE. A byte pushed during a burst can extend that burst up to BURST_MAX bytes.
- **Outputs:** `count` and `in_ready` reflect the register state after each edge.

## Test plan
1. **Reset values:** assert `rst_n`=0 with random inputs -> `drv_en`=0, `drv_data`=00, `bus_req`=0, `busy`=0, `count`=0, `in_ready`=1.
2. **Single byte:** `bus_gnt` tied 1; push 8'hAA -> `bus_req` rises 1 cycle after the push edge; `drv_en`=1 for exactly 1 cycle with `drv_data`=AA; then 1 TURN cycle with `bus_req`=0; FSM returns to IDLE with `count`=0.
3. **Full FIFO and burst limit:** hold `bus_gnt`=0; push 11, 22, 33, 44 -> `count`=4 and `in_ready`=0; a 5th byte 55 is held. Raise `bus_gnt` -> four consecutive `drv_en` cycles carrying 11, 22, 33, 44. Byte 55 is accepted during the burst, then sent alone in a second burst after a 3-cycle gap.
4. **Grant loss:** 4 bytes queued; drop `bus_gnt` during the 2nd DRIVE cycle -> bytes 1 and 2 are sent; TURN and IDLE follow; `bus_req` reasserts. Restoring `bus_gnt` sends bytes 3 and 4.
5. **Grant withheld:** push 1 byte with `bus_gnt` held 0 for 50 cycles -> `bus_req`=1 and `drv_en`=0 throughout; the byte is sent 1 cycle after the grant is sampled.
6. **Reset mid-burst:** pulse `rst_n` low between clock edges during the 2nd byte of a 4-byte burst -> `drv_en` falls before the next edge; `count`=0; no further `drv_en` until new data is pushed.

Source files
------------

// File: rtl/bus_tx_sequencer.sv
// Byte FIFO feeding an 8-bit tri-state driver, with request/grant bus arbitration.
// Bytes leave in bursts of up to BURST_MAX; every burst is followed by a turnaround cycle.
module bus_tx_sequencer #(
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic [7:0]               drv_data,
  output logic                     drv_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("bus_tx_sequencer: DEPTH must be a power of two and at least 2");
    end
    if (BURST_MAX < 1) begin : g_bad_burst
      $error("bus_tx_sequencer: BURST_MAX must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [7:0]      mem_q [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic            last_s;

  // Next-state, pointer and occupancy logic.
  always_comb begin
    push_s   = in_valid && (count_q != FULL_CNT);
    pop_s    = (state_q == S_DRIVE);
    // Burst ends when the FIFO drains, the burst limit is hit, or the grant drops.
    last_s   = ((count_q == CW'(1)) && !push_s) || (burst_q == BURST_LAST) || !bus_gnt;
    state_d  = state_q;
    burst_d  = burst_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_DRIVE;
          burst_d = {BW{1'b0}};
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRIVE: begin
        burst_d = burst_q + BW'(1);
        if (last_s) begin
          state_d = S_TURN;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, FIFO storage and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      burst_q  <= {BW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

  // Outputs depend only on registers, so inputs cannot glitch them; reset forces them idle.
  assign drv_en   = (state_q == S_DRIVE);
  assign bus_req  = (state_q == S_REQ) || (state_q == S_DRIVE);
  assign busy     = (state_q != S_IDLE);
  assign drv_data = (state_q == S_DRIVE) ? mem_q[rd_ptr_q] : 8'h00;
  assign count    = count_q;
  assign in_ready = (count_q != FULL_CNT);

endmodule

// File: tb/tb_bus_tx_sequencer.sv
// Directed bench for bus_tx_sequencer: a queue-based transaction model checked every cycle,
// plus literal expectations for the key timing points of each scenario.
module tb_bus_tx_sequencer;

  localparam int DEPTH     = 4;
  localparam int BURST_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] drv_data;
  logic       drv_en;
  logic       busy;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: bytes waiting, whether we are driving, requesting or turning around,
  // and how many bytes the current burst has sent.
  logic [7:0] q[$];
  bit m_drv, m_req, m_turn;
  int m_sent;

  bus_tx_sequencer #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .drv_data(drv_data), .drv_en(drv_en), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_drv  = 1'b0;
    m_req  = 1'b0;
    m_turn = 1'b0;
    m_sent = 0;
  endtask

  // One clock: the model consumes the same inputs the DUT sampled at this edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid && (q.size() < DEPTH);
      if (m_drv) begin
        void'(q.pop_front());
        m_sent++;
        if ((q.size() == 0 && !acc) || m_sent == BURST_MAX || !bus_gnt) begin
          m_drv  = 1'b0;
          m_turn = 1'b1;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else if (m_req) begin
        if (bus_gnt) begin
          m_req  = 1'b0;
          m_drv  = 1'b1;
          m_sent = 0;
        end
      end else if (q.size() != 0) begin
        m_req = 1'b1;
      end
      if (acc) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic push_tick(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_drv_en",   drv_en,   m_drv);
      check("m_drv_data", drv_data, m_drv ? 32'(q[0]) : 32'd0);
      check("m_bus_req",  bus_req,  m_req || m_drv);
      check("m_busy",     busy,     m_req || m_drv || m_turn);
      check("m_count",    count,    q.size());
      check("m_in_ready", in_ready, q.size() < DEPTH);
    end
  end

  initial begin
    rst_n = 1'b1; in_data = 8'h00; in_valid = 1'b0; bus_gnt = 1'b0;
    mreset();
    // 1. reset values with random inputs
    #1 rst_n = 1'b0;
    in_valid = 1'($urandom); bus_gnt = 1'($urandom); in_data = 8'($urandom);
    chk_on = 1'b1;
    #2;
    check("rst_drv_en", drv_en, 0);   check("rst_drv_data", drv_data, 8'h00);
    check("rst_bus_req", bus_req, 0); check("rst_busy", busy, 0);
    check("rst_count", count, 0);     check("rst_in_ready", in_ready, 1);
    tick();
    in_valid = 1'($urandom); bus_gnt = 1'($urandom); in_data = 8'($urandom);
    tick();
    in_valid = 1'b0; bus_gnt = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2. single byte, grant tied high
    bus_gnt = 1'b1;
    push_tick(8'hAA);
    check("s2_no_req_yet", bus_req, 0);
    tick(); check("s2_req", bus_req, 1);   check("s2_req_noen", drv_en, 0);
    tick(); check("s2_en", drv_en, 1);     check("s2_data", drv_data, 8'hAA);
    tick(); check("s2_turn_en", drv_en, 0); check("s2_turn_req", bus_req, 0); check("s2_turn_busy", busy, 1);
    tick(); check("s2_idle", busy, 0);     check("s2_cnt", count, 0);

    // 3. full FIFO, burst limit, byte held then sent in a second burst
    bus_gnt = 1'b0;
    push_tick(8'h11); push_tick(8'h22); push_tick(8'h33); push_tick(8'h44);
    check("s3_full_cnt", count, 4); check("s3_full_rdy", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h55;
    tick(); check("s3_held_cnt", count, 4);
    bus_gnt = 1'b1;
    tick(); check("s3_b1", drv_data, 8'h11); check("s3_b1_en", drv_en, 1);
    tick(); check("s3_b2", drv_data, 8'h22); check("s3_b2_cnt", count, 3);
    tick(); in_valid = 1'b0;
    check("s3_b3", drv_data, 8'h33); check("s3_b3_cnt", count, 3);
    tick(); check("s3_b4", drv_data, 8'h44);
    tick(); check("s3_turn_en", drv_en, 0); check("s3_turn_req", bus_req, 0); check("s3_turn_cnt", count, 1);
    tick(); check("s3_gap_idle", busy, 0);
    tick(); check("s3_gap_req", bus_req, 1); check("s3_gap_noen", drv_en, 0);
    tick(); check("s3_b5", drv_data, 8'h55); check("s3_b5_en", drv_en, 1);
    tick(); check("s3_turn2", drv_en, 0);
    tick(); check("s3_empty", count, 0);

    // 4. grant loss during the 2nd byte
    bus_gnt = 1'b0;
    push_tick(8'hA1); push_tick(8'hA2); push_tick(8'hA3); push_tick(8'hA4);
    bus_gnt = 1'b1;
    tick(); check("s4_b1", drv_data, 8'hA1);
    tick(); check("s4_b2", drv_data, 8'hA2);
    bus_gnt = 1'b0;
    tick(); check("s4_turn", drv_en, 0); check("s4_turn_cnt", count, 2);
    tick(); check("s4_idle", busy, 0);
    tick(); check("s4_rereq", bus_req, 1);
    tick(); tick();
    bus_gnt = 1'b1;
    tick(); check("s4_b3", drv_data, 8'hA3);
    tick(); check("s4_b4", drv_data, 8'hA4);
    tick(); check("s4_done_cnt", count, 0);
    tick();

    // 5. grant withheld for 50 cycles
    bus_gnt = 1'b0;
    push_tick(8'h5A);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("s5_req_hold", bus_req, 1);
      check("s5_no_en", drv_en, 0);
    end
    bus_gnt = 1'b1;
    tick(); check("s5_sent", drv_data, 8'h5A); check("s5_sent_en", drv_en, 1);
    tick(); tick();

    // 6. reset pulse between edges during the 2nd byte
    bus_gnt = 1'b0;
    push_tick(8'hB1); push_tick(8'hB2); push_tick(8'hB3); push_tick(8'hB4);
    bus_gnt = 1'b1;
    tick(); check("s6_b1", drv_data, 8'hB1);
    tick(); check("s6_b2_en", drv_en, 1);
    #1 rst_n = 1'b0;
    mreset();
    #1;
    check("s6_async_en", drv_en, 0); check("s6_async_cnt", count, 0);
    check("s6_async_req", bus_req, 0); check("s6_async_data", drv_data, 8'h00);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s6_quiet", drv_en, 0);
    end
    push_tick(8'hC1);
    tick(); check("s6_new_req", bus_req, 1);
    tick(); check("s6_new_data", drv_data, 8'hC1);
    tick(); tick();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
